// File: rtl/hazard_pkg.sv
// Shared types and constants for the operand hazard scoreboard.
package hazard_pkg;

  localparam int unsigned MAX_RW  = 8;
  localparam int unsigned XZR_IDX = 31;

  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned FWD_EX  = 1;
  localparam int unsigned FWD_MEM = 2;
  localparam int unsigned FWD_WB  = 3;

  // rd is held at a fixed maximum width so the struct is independent of NUM_REGS
  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] rd;
    logic              regwrite;
    logic              load;
  } entry_t;

  function automatic int unsigned xzr_index(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side issue/source bundle and scoreboard hazard results.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NUM_SRC  = 3
);
  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic                            issue_valid;
  logic [RW-1:0]                   issue_rd;
  logic                            issue_regwrite;
  logic                            issue_load;
  logic [NUM_SRC-1:0][RW-1:0]      src_addr;
  logic [NUM_SRC-1:0]              src_used;
  logic                            flush;
  logic                            stall;
  logic [NUM_SRC-1:0][FW-1:0]      fwd_sel;

  modport master (
    output issue_valid, issue_rd, issue_regwrite, issue_load,
    output src_addr, src_used, flush,
    input  stall, fwd_sel
  );

  modport slave (
    input  issue_valid, issue_rd, issue_regwrite, issue_load,
    input  src_addr, src_used, flush,
    output stall, fwd_sel
  );

endinterface

// File: rtl/hazard_match.sv
// Per-source-port priority match across the tracked pipeline stages.
module hazard_match
  import hazard_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned DEPTH    = 3,
  parameter  int unsigned LOAD_LAT = 1,
  localparam int unsigned RW       = $clog2(NUM_REGS),
  localparam int unsigned FW       = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH:1] stages,
  input  logic [RW-1:0]    src_addr,
  input  logic             src_used,
  output logic [FW-1:0]    sel,
  output logic             load_hit
);

  logic src_ok;

  assign src_ok = src_used && (src_addr != RW'(xzr_index(NUM_REGS)));

  // Oldest-to-youngest scan so the youngest matching producer overwrites sel
  always_comb begin
    sel      = FW'(FWD_RF);
    load_hit = 1'b0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (src_ok && stages[k].valid && stages[k].regwrite &&
          (stages[k].rd == MAX_RW'(src_addr))) begin
        sel = FW'(k);
        if ((k <= LOAD_LAT) && stages[k].load) begin
          load_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use stall and forwarding-select scoreboard over DEPTH post-decode stages.
// Optional stall counter enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_scoreboard_if.slave      bus
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]             stall_count
`endif
);

  localparam int unsigned FW = $clog2(DEPTH + 1);

  entry_t [DEPTH:1]           stages_q;
  entry_t                     issue_entry;
  logic [NUM_SRC-1:0]         load_hit;
  logic [NUM_SRC-1:0][FW-1:0] fwd;
  logic                       stall;
  logic                       accept;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    hazard_match #(
      .NUM_REGS (NUM_REGS),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .stages   (stages_q),
      .src_addr (bus.src_addr[p]),
      .src_used (bus.src_used[p]),
      .sel      (fwd[p]),
      .load_hit (load_hit[p])
    );
  end

  // Flush wins over a load-use stall: the consumer is squashed anyway
  assign stall       = (|load_hit) && !bus.flush;
  assign accept      = bus.issue_valid && !stall && !bus.flush;
  assign bus.stall   = stall;
  assign bus.fwd_sel = fwd;

  always_comb begin
    issue_entry          = '0;
    issue_entry.valid    = bus.issue_valid;
    issue_entry.rd       = MAX_RW'(bus.issue_rd);
    issue_entry.regwrite = bus.issue_regwrite;
    issue_entry.load     = bus.issue_load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages_q <= '0;
    end else begin
      for (int unsigned k = DEPTH; k >= 2; k--) begin
        stages_q[k] <= stages_q[k-1];
      end
      stages_q[1] <= accept ? issue_entry : '0;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
